// File: rtl/pkt_fifo.sv
// Packet FIFO with sop/eop framing enforcement, occupancy/packet status and sticky errors.
// First-word-fall-through read; optional store-and-forward gating of rd_vld.
module pkt_fifo #(
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter bit          STORE_FWD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_vld,
    input  logic                    wr_sop,
    input  logic                    wr_eop,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    output logic                    rd_vld,
    input  logic                    rd_ready,
    output logic                    rd_sop,
    output logic                    rd_eop,
    output logic [DATA_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH):0]  pkt_cnt,
    output logic                    almost_full,
    output logic                    overflow,
    output logic                    frame_err,
    input  logic                    err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {IDLE, INPKT} frame_t;

    frame_t              state, state_nx;
    logic [PW-1:0]       wptr, rptr;
    logic [DATA_W+1:0]   mem [DEPTH];
    logic [DATA_W+1:0]   head;
    logic                empty, full;
    logic                beat, legal, accept, viol, rd_fire;
    logic                pkt_inc, pkt_dec;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_ready = !full;
    assign count    = wptr - rptr;
    assign almost_full = (count >= PW'(AF_LEVEL));

    assign head    = mem[rptr[AW-1:0]];
    assign rd_sop  = head[DATA_W+1];
    assign rd_eop  = head[DATA_W];
    assign rd_data = head[DATA_W-1:0];

    // The full term lets packets longer than DEPTH drain as cut-through instead of deadlocking.
    assign rd_vld  = !empty && (!STORE_FWD || (pkt_cnt != '0) || full);
    assign rd_fire = rd_vld && rd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            state_nx = wr_eop ? IDLE : INPKT;
        end
    end

    always_comb begin
        legal = 1'b0;
        unique case (state)
            IDLE:  legal = wr_sop;
            INPKT: legal = !wr_sop;
        endcase
        beat   = wr_vld && !full;
        accept = beat && legal;
        viol   = beat && !legal;
    end

    assign pkt_inc = accept && wr_eop;
    assign pkt_dec = rd_fire && rd_eop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            pkt_cnt   <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_fire) begin
                rptr <= rptr + PW'(1);
            end
            if (pkt_inc && !pkt_dec) begin
                pkt_cnt <= pkt_cnt + PW'(1);
            end else if (!pkt_inc && pkt_dec) begin
                pkt_cnt <= pkt_cnt - PW'(1);
            end
            overflow  <= (wr_vld && full) || (overflow && !err_clr);
            frame_err <= viol || (frame_err && !err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr[AW-1:0]] <= {wr_sop, wr_eop, wr_data};
        end
    end

endmodule
